pc_unit: RTL and testbench

- Parametrised next-generation program counter for the microprocessor fetch path. Replaces the fixed 6-bit, two-phase-clock PC.
- Runs on a single clock.
- Adds PC-relative branches, call/return through an internal return-address stack (RAS), stall/hold, and error signalling.
- Sits between the decode/control unit, which drives pc_latch_data, pc_ctl, imm and sr1_val, and the instruction memory address port, which consumes pc_out.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_unit.sv | 102 ++++++++++
 tb/tb_pc_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-path program counter.
// Contents: pc_ctl width and encodings, and the packed error-pulse record.
// Decode and the bench import this package.
package pc_pkg;
  localparam int PC_CTL_W = 3;
  typedef logic [PC_CTL_W-1:0] pc_ctl_t;

  localparam pc_ctl_t PC_INC     = 3'b000;
  localparam pc_ctl_t PC_BR_ABS  = 3'b001;
  localparam pc_ctl_t PC_JMP_REG = 3'b010;
  localparam pc_ctl_t PC_BR_REL  = 3'b011;
  localparam pc_ctl_t PC_CALL    = 3'b100;
  localparam pc_ctl_t PC_RET     = 3'b101;

  // Error pulses, registered together in pc_unit.
  typedef struct packed {
    logic ovf;
    logic unf;
    logic ill;
  } pc_err_t;
endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO storage addressed by a top pointer.
// The pointer doubles as the entry count.
// Ports:
//   gclk, grst_n  clock, async active-low reset (resets the pointer only)
//   push_i        write push_data_i at the top; ignored when full
//   pop_i         drop the top entry; ignored when empty
//   push_data_i   return address to store
//   top_data_o    most recent entry (meaningless when empty)
//   count_o       number of valid entries
//   full_o        count == DEPTH
//   empty_o       count == 0
module pc_ras #(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  push_data_i,
  output logic [W-1:0]  top_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Sized to the index range so an empty-stack read never leaves the array.
  logic [W-1:0]  mem_q [2**IW];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          do_push, do_pop;

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o & ~push_i;
  assign wr_idx     = IW'(cnt_q);
  assign rd_idx     = IW'(cnt_q - CW'(1));
  assign top_data_o = mem_q[rd_idx];
  assign count_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  // Contents are don't-care after reset; no reset on storage.
  always_ff @(posedge gclk)
    if (do_push) mem_q[wr_idx] <= push_data_i;
endmodule

// File: rtl/pc_unit.sv
// Program counter for the fetch path: next-PC mux, call/return via pc_ras,
// error detection and registered one-cycle error pulses.
// Optional macro PC_TRAP_EN: any error condition redirects to TRAP_VECTOR.
// Ports:
//   clka, reset_n  single clock, async active-low reset
//   pc_latch_data  update strobe; PC/stack hold when low
//   pc_ctl         next-PC select (pc_pkg encodings; 110/111 reserved)
//   imm            absolute target or signed relative offset
//   sr1_val        register-indirect target
//   pc_out         current PC
//   ras_count      valid stack entries
//   ras_ovf/ras_unf/illegal_ctl  one-cycle error pulses
module pc_unit import pc_pkg::*; #(
  parameter  int                 PC_BITS      = 6,
  parameter  int                 RAS_DEPTH    = 4,
  parameter  logic [PC_BITS-1:0] RESET_VECTOR = '0,
  parameter  logic [PC_BITS-1:0] TRAP_VECTOR  = '1,
  localparam int                 CW           = $clog2(RAS_DEPTH+1)
) (
  input  logic               clka,
  input  logic               reset_n,
  input  logic               pc_latch_data,
  input  pc_ctl_t            pc_ctl,
  input  logic [PC_BITS-1:0] imm,
  input  logic [PC_BITS-1:0] sr1_val,
  output logic [PC_BITS-1:0] pc_out,
  output logic [CW-1:0]      ras_count,
  output logic               ras_ovf,
  output logic               ras_unf,
  output logic               illegal_ctl
);
  logic [PC_BITS-1:0] pc_q, pc_d, pc_inc, ras_top;
  pc_err_t            err_q, err_d;
  logic               push, pop, ras_full, ras_empty;

  assign pc_inc = pc_q + PC_BITS'(1);

  pc_ras #(.W(PC_BITS), .DEPTH(RAS_DEPTH)) u_ras (
    .gclk        (clka),
    .grst_n      (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .top_data_o  (ras_top),
    .count_o     (ras_count),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    err_d = '0;
    push  = 1'b0;
    pop   = 1'b0;
    if (pc_latch_data) begin
      case (pc_ctl)
        PC_INC:     pc_d = pc_inc;
        PC_BR_ABS:  pc_d = imm;
        PC_JMP_REG: pc_d = sr1_val;
        // Same-width add is sign-extend-and-wrap for a two's-complement imm.
        PC_BR_REL:  pc_d = pc_q + imm;
        PC_CALL: begin
          pc_d = imm;
          if (ras_full) err_d.ovf = 1'b1;
          else          push      = 1'b1;
        end
        PC_RET: begin
          if (ras_empty) begin
            err_d.unf = 1'b1;
            pc_d      = pc_inc;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: err_d.ill = 1'b1;
      endcase
    end
`ifdef PC_TRAP_EN
    if (|err_d) pc_d = TRAP_VECTOR;
`endif
  end

`ifndef PC_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^TRAP_VECTOR;
`endif

  always_ff @(posedge clka or negedge reset_n)
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      err_q <= '0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end

  assign pc_out      = pc_q;
  assign ras_ovf     = err_q.ovf;
  assign ras_unf     = err_q.unf;
  assign illegal_ctl = err_q.ill;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  import pc_pkg::*;

  localparam int PCB = 6;
  localparam int D   = 4;
  localparam int CW  = $clog2(D+1);
  localparam int MOD = 1 << PCB;
  localparam int TRAPV = MOD - 1;

  logic           clka = 1'b0;
  logic           reset_n = 1'b0;
  logic           pc_latch_data = 1'b0;
  pc_ctl_t        pc_ctl = '0;
  logic [PCB-1:0] imm = '0, sr1_val = '0;
  logic [PCB-1:0] pc_out;
  logic [CW-1:0]  ras_count;
  logic           ras_ovf, ras_unf, illegal_ctl;

  int checks = 0, errors = 0;

  pc_unit #(.PC_BITS(PCB), .RAS_DEPTH(D)) dut (
    .clka(clka), .reset_n(reset_n), .pc_latch_data(pc_latch_data),
    .pc_ctl(pc_ctl), .imm(imm), .sr1_val(sr1_val), .pc_out(pc_out),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .illegal_ctl(illegal_ctl)
  );

  always #5 clka = ~clka;

  // ---------------- reference model ----------------
  int m_pc;
  int m_st[$];
  bit m_ovf, m_unf, m_ill;

  function automatic bit trap_on();
`ifdef PC_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = 0; m_st.delete(); m_ovf = 0; m_unf = 0; m_ill = 0;
  endtask

  task automatic model_step(input bit s, input int c, input int im, input int r);
    int off;
    m_ovf = 0; m_unf = 0; m_ill = 0;
    if (s) begin
      case (c)
        0: m_pc = (m_pc + 1) % MOD;
        1: m_pc = im;
        2: m_pc = r;
        3: begin
          off  = (im >= MOD/2) ? im - MOD : im;
          m_pc = (m_pc + off + MOD) % MOD;
        end
        4: begin
          if (m_st.size() == D) m_ovf = 1;
          else m_st.push_back((m_pc + 1) % MOD);
          m_pc = im;
        end
        5: begin
          if (m_st.size() == 0) begin m_unf = 1; m_pc = (m_pc + 1) % MOD; end
          else m_pc = m_st.pop_back();
        end
        default: m_ill = 1;
      endcase
      if (trap_on() && (m_ovf || m_unf || m_ill)) m_pc = TRAPV;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, take the edge, then sample 1ns later.
  task automatic step(input bit s, input int c, input int im, input int r);
    pc_latch_data = s;
    pc_ctl        = pc_ctl_t'(c);
    imm           = PCB'(im);
    sr1_val       = PCB'(r);
    @(posedge clka);
    model_step(s, c, im, r);
    #1;
  endtask

  typedef struct {
    bit s; int c; int im; int r;
    int pc; int cnt; bit o; bit u; bit i; bit e;
  } vec_t;

  function automatic vec_t v(bit s, int c, int im, int r, int pc, int cnt,
                             bit o, bit u, bit i, bit e);
    vec_t x;
    x.s = s; x.c = c; x.im = im; x.r = r; x.pc = pc; x.cnt = cnt;
    x.o = o; x.u = u; x.i = i; x.e = e;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    int exp_pc;
    // s c  im  r   pc  cnt o u i e  (e: error entry -> TRAPV under PC_TRAP_EN)
    tbl.push_back(v(1, 1,  2, 0,   2, 0, 0,0,0,0));
    tbl.push_back(v(1, 3, 60, 0,  62, 0, 0,0,0,0));  // 2 + (-4) wraps down
    tbl.push_back(v(1, 3,  5, 0,   3, 0, 0,0,0,0));  // 62 + 5 wraps up
    tbl.push_back(v(1, 1, 10, 0,  10, 0, 0,0,0,0));
    tbl.push_back(v(1, 0,  0, 0,  11, 0, 0,0,0,0));
    tbl.push_back(v(1, 2,  0,32,  32, 0, 0,0,0,0));
    tbl.push_back(v(1, 0,  0, 0,  33, 0, 0,0,0,0));
    tbl.push_back(v(1, 1,  5, 0,   5, 0, 0,0,0,0));
    tbl.push_back(v(1, 4, 20, 0,  20, 1, 0,0,0,0));
    tbl.push_back(v(1, 4, 40, 0,  40, 2, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,  21, 1, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,   6, 0, 0,0,0,0));
    tbl.push_back(v(0, 4, 50, 0,   6, 0, 0,0,0,0));  // unstrobed CALL holds
    tbl.push_back(v(1, 4, 10, 0,  10, 1, 0,0,0,0));
    tbl.push_back(v(1, 4, 20, 0,  20, 2, 0,0,0,0));
    tbl.push_back(v(1, 4, 30, 0,  30, 3, 0,0,0,0));
    tbl.push_back(v(1, 4, 40, 0,  40, 4, 0,0,0,0));
    tbl.push_back(v(1, 4, 50, 0,  50, 4, 1,0,0,1));  // full-stack CALL
    tbl.push_back(v(0, 0,  0, 0,  50, 4, 0,0,0,1));  // pulse gone
    tbl.push_back(v(1, 5,  0, 0,  31, 3, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,  21, 2, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,  11, 1, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,   7, 0, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,   8, 0, 0,1,0,1));  // empty-stack RET
    tbl.push_back(v(1, 1,  9, 0,   9, 0, 0,0,0,0));
    tbl.push_back(v(1, 6,  0, 0,   9, 0, 0,0,1,1));
    tbl.push_back(v(1, 7,  0, 0,   9, 0, 0,0,1,1));
    tbl.push_back(v(1, 1,  9, 0,   9, 0, 0,0,0,0));
    tbl.push_back(v(1, 1, 63, 0,  63, 0, 0,0,0,0));
    tbl.push_back(v(1, 4,  0, 0,   0, 1, 0,0,0,0));  // pushes 0
    tbl.push_back(v(1, 5,  0, 0,   0, 0, 0,0,0,0));
    tbl.push_back(v(1, 4,  5, 0,   5, 1, 0,0,0,0));
    tbl.push_back(v(1, 5,  0, 0,   1, 0, 0,0,0,0));

    // ---- reset state ----
    model_reset();
    repeat (2) @(posedge clka);
    #1;
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_cnt", int'(ras_count), 0);
    chk("rst_pulses", int'({ras_ovf, ras_unf, illegal_ctl}), 0);
    reset_n = 1'b1;

    // ---- wrap: 64 INCs from 0 ----
    for (int k = 0; k < MOD; k++) begin
      step(1, 0, 0, 0);
      chk("wrap_pc", int'(pc_out), (k + 1) % MOD);
    end

    // ---- directed table ----
    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].c, tbl[k].im, tbl[k].r);
      exp_pc = (trap_on() && tbl[k].e) ? TRAPV : tbl[k].pc;
      chk($sformatf("tbl%0d_pc", k), int'(pc_out), exp_pc);
      chk($sformatf("tbl%0d_cnt", k), int'(ras_count), tbl[k].cnt);
      chk($sformatf("tbl%0d_ovf", k), int'(ras_ovf), int'(tbl[k].o));
      chk($sformatf("tbl%0d_unf", k), int'(ras_unf), int'(tbl[k].u));
      chk($sformatf("tbl%0d_ill", k), int'(illegal_ctl), int'(tbl[k].i));
    end

    // ---- asynchronous reset mid-run at pc=17 with a live stack entry ----
    step(1, 1, 16, 0);
    step(1, 4, 17, 0);
    chk("pre_rst_pc", int'(pc_out), 17);
    chk("pre_rst_cnt", int'(ras_count), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc_out), 0);
    chk("async_rst_cnt", int'(ras_count), 0);
    @(posedge clka);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 33, 44);
      chk("rel_hold_pc", int'(pc_out), 0);
      chk("rel_hold_cnt", int'(ras_count), 0);
    end

    // ---- randomized run against the model ----
    for (int k = 0; k < 600; k++) begin
      bit s;
      int c;
      s = ($urandom_range(0, 9) != 0);
      c = $urandom_range(0, 7);
      // Bias toward call/return so the stack reaches both extremes.
      if ($urandom_range(0, 2) == 0) c = 4 + $urandom_range(0, 1);
      step(s, c, $urandom_range(0, MOD-1), $urandom_range(0, MOD-1));
      chk("rnd_pc", int'(pc_out), m_pc);
      chk("rnd_cnt", int'(ras_count), m_st.size());
      chk("rnd_ovf", int'(ras_ovf), int'(m_ovf));
      chk("rnd_unf", int'(ras_unf), int'(m_unf));
      chk("rnd_ill", int'(illegal_ctl), int'(m_ill));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
